bit_serial_tx: RTL and testbench
================================

// Module: bit_serial_tx
// PURPOSE
//  Parallel-in/serial-out transmitter for the MAC unit's bit-serial operand link; the send end
//  of the link whose receive end is a DFF-based serial-in/parallel-out register.
//  Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clk.
//  Frame/last strobes mark bit boundaries, so the receiver needs no bit counter of its own.
// PARAMETERS
//  WIDTH      8   word width in bits, >= 1
//  LSB_FIRST  1   1: bit 0 sent first; 0: bit WIDTH-1 sent first
// PORTS
//  clk         in   1      clock, all state updates on rising edge
//  rst         in   1      asynchronous reset, active-high
//  load_valid  in   1      load_data is valid this cycle
//  load_ready  out  1      transmitter can accept a word this cycle
//  load_data   in   WIDTH  parallel word to transmit
//  ser_out     out  1      serial data bit, registered
//  ser_frame   out  1      high while ser_out carries a valid bit, registered
//  ser_last    out  1      high with the final bit of a word, registered
//  busy        out  1      high while a word is in flight, registered
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE, shift reg=0, count=0; ser_out=0, ser_frame=0,
//    ser_last=0, busy=0. load_ready is forced 0 while rst is high, so no word is accepted.
//  - Handshake: transfer when load_valid && load_ready at a rising edge; load_data is captured at
//    that edge. load_valid without load_ready is ignored. No drop, no duplication.
//  - load_ready (combinational) = !rst && (state==IDLE || (state==SHIFT && count==WIDTH-1)).
//  - FSM, 2 states:
//    IDLE : ser_frame=0, ser_out=0, busy=0. On transfer -> SHIFT, count=0.
//    SHIFT: ser_frame=1, busy=1, ser_out=current bit. Each edge: shift, count++.
//           count==WIDTH-1 (ser_last=1): on transfer reload, count=0, stay SHIFT (back-to-back);
//           otherwise -> IDLE.
//  - Latency: word accepted at edge N -> bit 0 (or WIDTH-1 if !LSB_FIRST) on ser_out after N,
//    final bit after edge N+WIDTH-1. Back-to-back: first bit of the next word follows the last
//    bit with no gap; ser_frame stays high across the word boundary.
//  - Count width = max(1, $clog2(WIDTH)); count never exceeds WIDTH-1, no wrap.
//  - WIDTH==1: every bit is last; ser_last=ser_frame; load_ready is high every SHIFT cycle.
//  - rst mid-word: the word is abandoned, outputs drop to reset values asynchronously,
//    and the partial word is not resumed after reset release.
//  - load_data changes while in SHIFT have no effect (captured copy only).
// STRUCTURE
//  - Shared include: state encodings (ST_IDLE=1'b0, ST_SHIFT=1'b1) and the CLOG2-with-min-1
//    width helper, reused by the matching receiver.
//  - Sub-module piso_shift_register: WIDTH DFFs with async active-high reset, parallel load,
//    shift enable, and a direction set by LSB_FIRST. The FSM, counter and strobes stay in the top.
// TESTING
//  1. rst=1 at t=0, release after 2 clk -> all outputs 0 during rst, load_ready=0; then
//     load_ready=1, busy=0.
//  2. WIDTH=8, LSB_FIRST=1, load 8'hA5 once -> ser_out 1,0,1,0,0,1,0,1 on 8 consecutive cycles;
//     ser_frame=1 for all 8, ser_last only on the 8th; then IDLE with load_ready=1.
//  3. Back-to-back 8'hA5 then 8'h3C (load_valid held) -> 16 contiguous framed bits, second word
//     accepted in the ser_last cycle, ser_last pulses twice.
//  4. LSB_FIRST=0, load 8'h80 -> ser_out 1 then seven 0s. Toggling load_data mid-word leaves the
//     bits unchanged.
//  5. Assert rst on the 4th bit of 8'hFF -> ser_out/ser_frame/busy drop to 0 before the next edge;
//     after release, a load of 8'h01 sends 1 then 0s with no leftover bits.
//  6. WIDTH=1, load_valid held with alternating 1/0 -> ser_out 1,0,1,0; ser_last=ser_frame=1
//     each cycle.

Source files
------------

// File: rtl/bit_serial_tx_pkg.sv
// Shared definitions for the bit-serial operand link (transmitter and matching receiver).
package bit_serial_tx_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } tx_state_e;

  // Counter width for a WIDTH-bit word; never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bit_serial_tx_piso_shift_register.sv
// WIDTH-bit parallel-in/serial-out register; zero-fills as it shifts toward the output end.
module piso_shift_register #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             bit_o
);

  logic [WIDTH-1:0] sreg_q, sreg_d;

  always_comb begin
    sreg_d = sreg_q;
    if (load_i) begin
      sreg_d = data_i;
    end else if (shift_i) begin
      sreg_d = LSB_FIRST ? (sreg_q >> 1) : (sreg_q << 1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_q <= '0;
    end else begin
      sreg_q <= sreg_d;
    end
  end

  assign bit_o = LSB_FIRST ? sreg_q[0] : sreg_q[WIDTH-1];

endmodule

// File: rtl/bit_serial_tx.sv
// Bit-serial operand transmitter: accepts a word on valid/ready and shifts it out one bit per clk
// with frame/last strobes marking the bit boundaries.
module bit_serial_tx
  import bit_serial_tx_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             ser_out,
  output logic             ser_frame,
  output logic             ser_last,
  output logic             busy
);

  localparam int unsigned      CNT_W    = clog2_min1(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             last_q, last_d;
  logic             load_en, shift_en, at_last, xfer;

  assign at_last    = (state_q == ST_SHIFT) && (count_q == LAST_CNT);
  assign load_ready = !rst && ((state_q == ST_IDLE) || at_last);
  assign xfer       = load_valid && load_ready;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    load_en  = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          state_d = ST_SHIFT;
          count_d = '0;
          load_en = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (at_last) begin
          if (xfer) begin
            count_d = '0;
            load_en = 1'b1;
          end else begin
            // Shifting out the final bit leaves the register all-zero, so ser_out idles low.
            state_d  = ST_IDLE;
            count_d  = '0;
            shift_en = 1'b1;
          end
        end else begin
          count_d  = count_q + 1'b1;
          shift_en = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    last_d = (state_d == ST_SHIFT) && (count_d == LAST_CNT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      last_q  <= last_d;
    end
  end

  piso_shift_register #(
    .WIDTH    (WIDTH),
    .LSB_FIRST(LSB_FIRST)
  ) u_piso (
    .clk    (clk),
    .rst    (rst),
    .load_i (load_en),
    .shift_i(shift_en),
    .data_i (load_data),
    .bit_o  (ser_out)
  );

  assign ser_frame = (state_q == ST_SHIFT);
  assign busy      = (state_q == ST_SHIFT);
  assign ser_last  = last_q;

endmodule

// File: tb/tb_bit_serial_tx.sv
// Scoreboard bench: three transmitters (8-bit LSB-first, 8-bit MSB-first, 1-bit) checked against
// a word-to-bit-list model.
module tb_bit_serial_tx;

  localparam int ND = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lv0 = 1'b0;
  logic       lv1 = 1'b0;
  logic [7:0] ld0 = '0;
  logic [0:0] ld1 = '0;

  logic [ND-1:0] rdy, so, fr, la, bz;

  logic [1:0] expq [ND][$];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bit_serial_tx #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst(rst), .load_valid(lv0), .load_ready(rdy[0]), .load_data(ld0),
    .ser_out(so[0]), .ser_frame(fr[0]), .ser_last(la[0]), .busy(bz[0]));

  bit_serial_tx #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst(rst), .load_valid(lv0), .load_ready(rdy[1]), .load_data(ld0),
    .ser_out(so[1]), .ser_frame(fr[1]), .ser_last(la[1]), .busy(bz[1]));

  bit_serial_tx #(.WIDTH(1), .LSB_FIRST(1'b1)) u_w1 (
    .clk(clk), .rst(rst), .load_valid(lv1), .load_ready(rdy[2]), .load_data(ld1),
    .ser_out(so[2]), .ser_frame(fr[2]), .ser_last(la[2]), .busy(bz[2]));

  task automatic check(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", name, d, $time, act, exp);
    end
  endtask

  // Model: a word becomes WIDTH {bit, last} pairs in transmission order.
  function automatic void push_word(input int d);
    int unsigned w   = (d == 2) ? 1 : 8;
    bit          lsb = (d != 1);
    logic [7:0]  data = (d == 2) ? {7'b0, ld1} : ld0;
    for (int unsigned i = 0; i < w; i++) begin
      int unsigned idx = lsb ? i : (w - 1 - i);
      expq[d].push_back({data[idx], (i == w - 1)});
    end
  endfunction

  // Scoreboard input: record every accepted word (transfer occurs at the following rising edge).
  always begin
    @(negedge clk);
    #1;
    if (!rst) begin
      for (int d = 0; d < ND; d++) begin
        if (((d == 2) ? lv1 : lv0) && rdy[d]) push_word(d);
      end
    end
  end

  // Monitor: compare the serial link against the head of each expected queue.
  always @(negedge clk) begin
    logic [1:0] e;
    for (int d = 0; d < ND; d++) begin
      if (rst) begin
        check("rst_outs", d, {rdy[d], so[d], fr[d], la[d], bz[d]}, 32'h0);
      end else begin
        check("ready", d, rdy[d], expq[d].size() <= 1);
        check("frame_busy", d, {fr[d], bz[d]}, {2{expq[d].size() != 0}});
        if (expq[d].size() != 0) begin
          e = expq[d].pop_front();
          check("bit_last", d, {so[d], la[d]}, e);
        end else begin
          check("idle_bits", d, {so[d], la[d]}, 2'b00);
        end
      end
    end
  end

  task automatic send8(input logic [7:0] d);
    int unsigned n = 0;
    lv0 = 1'b1;
    ld0 = d;
    @(negedge clk);
    #2;
    while (!rdy[0] && n < 40) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("send_accept", 0, rdy[0], 1'b1);
    @(posedge clk);
    #1;
    lv0 = 1'b0;
    ld0 = 8'($urandom);
  endtask

  task automatic idle0(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
      lv0 = 1'b0;
      ld0 = 8'($urandom);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t: bench did not finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    idle0(2);

    send8(8'hA5);
    idle0(10);
    send8(8'hA5);
    send8(8'h3C);
    idle0(10);
    send8(8'h80);
    idle0(10);

    // Reset while the fourth bit of 8'hFF is on the line.
    send8(8'hFF);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    for (int d = 0; d < ND; d++) expq[d].delete();
    #1;
    for (int d = 0; d < ND; d++) begin
      check("rst_async", d, {rdy[d], so[d], fr[d], la[d], bz[d]}, 32'h0);
    end
    @(posedge clk);
    #3;
    rst = 1'b0;
    send8(8'h01);
    idle0(10);

    lv1 = 1'b1;
    ld1 = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      ld1 = ~ld1;
    end
    lv1 = 1'b0;
    idle0(4);

    fork
      begin
        repeat (25) begin
          if ($urandom_range(2) == 0) idle0($urandom_range(3));
          send8(8'($urandom));
        end
      end
      begin
        repeat (200) begin
          @(posedge clk);
          #1;
          lv1 = 1'($urandom);
          ld1 = 1'($urandom);
        end
        lv1 = 1'b0;
      end
    join

    idle0(12);
    for (int d = 0; d < ND; d++) check("drain", d, expq[d].size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
